conv_feeder: RTL
================

CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 Parameter DRAIN_CYC, default 4: idle cycles between the last ifmap byte and the first result capture (1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-high.
REQ-004 host_we  input  1  host write strobe into the operand buffer.
REQ-005 host_addr  input  6  buffer address: 0-8 filter weights (row-major), 9-33 ifmap 5x5 (row-major).
REQ-006 host_wdata  input  8  signed byte to store.
REQ-007 start  input  1  single-cycle request to run one convolution.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse when results are valid.
REQ-010 res_addr  input  4  result index 0-8 (row-major 3x3).
REQ-011 res_data  output  8  combinational read of the result buffer at res_addr.
REQ-012 drvA  output  8  ifmap stream to the array's readA port.
REQ-013 drvB  output  8  filter stream to the array's readB port.
REQ-014 array_write  input  8  saturated array output byte.
REQ-015 sat_cnt  output  4  saturated-result count (present only with CONV_FEEDER_SAT_CNT_EN).

Function
REQ-016 FSM states: IDLE, LOAD_FILT, STREAM, DRAIN, CAPTURE, DONE.
REQ-017 IDLE: a start with busy low moves the FSM to LOAD_FILT on the next edge; start in any other state is ignored.
REQ-018 LOAD_FILT: 9 cycles; drvB = filter[k] for k = 0..8, drvA = 0; then STREAM.
REQ-019 STREAM: 25 cycles; drvA = ifmap[k] for k = 0..24, drvB = 0; then DRAIN.
REQ-020 DRAIN: exactly DRAIN_CYC cycles; drvA = drvB = 0; then CAPTURE.
REQ-021 CAPTURE: 9 cycles; array_write is registered into result[k] for k = 0..8; then DONE.
REQ-022 DONE: done = 1 for one cycle, busy = 0 in that cycle; next state IDLE.
REQ-023 Latency: an accepted start at edge 0 gives done high in cycle 44 + DRAIN_CYC.
REQ-024 drvA and drvB are registered outputs and are 0 in IDLE and DONE.
REQ-025 host_we is honoured only when busy = 0; writes while busy are dropped and the buffer is unchanged.
REQ-026 host_addr 34-63 with host_we: no buffer effect.
REQ-027 host_we and start in the same IDLE cycle: the write commits at that edge, and the run streams the updated value.
REQ-028 res_addr 9-15 returns res_data = 0.
REQ-029 The result buffer holds its values until overwritten during the next CAPTURE, and is readable at all times.
REQ-030 Indices are modulo-counter based, with a single internal 5-bit element counter reset at each state entry.

Reset
REQ-031 RST asserted forces IDLE, busy = 0, done = 0, drvA = drvB = 0, result buffer all 0, sat_cnt = 0, regardless of the clock.
REQ-032 RST mid-run aborts the run without a done pulse; the operand buffer is cleared to 0.
REQ-033 After RST deasserts, the first edge can accept start or host_we.

Configuration
REQ-034 Macro CONV_FEEDER_SAT_CNT_EN defined: the sat_cnt port exists.
REQ-035 With the macro, sat_cnt clears on entry to LOAD_FILT.
REQ-036 With the macro, sat_cnt increments in CAPTURE for each captured byte equal to 8'h7F or 8'h80, and saturates at 15.
REQ-037 Macro undefined: no sat_cnt port or logic; all other behaviour is identical.

Verification
REQ-038 Load filter all 8'h01 and ifmap 0..24, start -> drvB shows 01 for 9 cycles, then drvA shows 0..24 for 25 cycles, with done at cycle 48 (DRAIN_CYC = 4).
REQ-039 Drive array_write = 8'h10 + k during CAPTURE -> res_data at res_addr k reads 8'h10 + k after done; res_addr 12 reads 0.
REQ-040 host_we to addr 3 with 8'hAA while busy -> the next run streams the old filter[3] value.
REQ-041 Assert start during STREAM, and assert host_we together with start in IDLE -> the mid-run start is ignored and the same-cycle write value is streamed.
REQ-042 RST pulse at STREAM element 10 -> all outputs 0 immediately, no done, and a new start runs a full sequence.
REQ-043 With CONV_FEEDER_SAT_CNT_EN, captures 7F, 80, 7F, 05, then 00 x5 -> sat_cnt = 3 at done.

Source files
------------

// File: rtl/conv_feeder.sv
// Operand buffer, stream sequencer and result buffer that feed a 3x3 convolution array.
// Optional feature: define CONV_FEEDER_SAT_CNT_EN to add the sat_cnt saturation counter port.
module conv_feeder #(
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       host_we,
    input  logic [5:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic [3:0] res_addr,
    output logic [7:0] res_data,
    output logic [7:0] drvA,
    output logic [7:0] drvB,
    input  logic [7:0] array_write
`ifdef CONV_FEEDER_SAT_CNT_EN
    ,
    output logic [3:0] sat_cnt
`endif
);

    localparam logic [4:0] DrainLast = 5'(DRAIN_CYC - 1);
    localparam logic [5:0] OpWords   = 6'd34;

    typedef enum logic [2:0] {
        StIdle,
        StLoadFilt,
        StStream,
        StDrain,
        StCapture,
        StDone
    } state_e;

    state_e     state_q;
    logic [4:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] drva_q;
    logic [7:0] drvb_q;

    logic [7:0] op_q [34];
    logic [7:0] res_q [9];

    logic       wr_en;
    logic [5:0] rd_idx;
    logic [7:0] rd_data;

    assign wr_en = host_we && !busy_q && (host_addr < OpWords);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 34; i++) begin
                op_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            op_q[host_addr] <= host_wdata;
        end
    end

    // Address of the operand the output registers load at the coming edge.
    always_comb begin
        rd_idx = 6'd0;
        case (state_q)
            StLoadFilt: rd_idx = (cnt_q == 5'd8) ? 6'd9 : ({1'b0, cnt_q} + 6'd1);
            StStream:   rd_idx = {1'b0, cnt_q} + 6'd10;
            default:    rd_idx = 6'd0;
        endcase
    end

    // Forward a same-edge host write so a start accompanied by a write streams the new value.
    always_comb begin
        rd_data = 8'h00;
        if (wr_en && (host_addr == rd_idx)) begin
            rd_data = host_wdata;
        end else if (rd_idx < OpWords) begin
            rd_data = op_q[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drva_q  <= 8'h00;
            drvb_q  <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLoadFilt;
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b1;
                        drvb_q  <= rd_data;
                    end
                end
                StLoadFilt: begin
                    if (cnt_q == 5'd8) begin
                        state_q <= StStream;
                        cnt_q   <= 5'd0;
                        drvb_q  <= 8'h00;
                        drva_q  <= rd_data;
                    end else begin
                        cnt_q  <= cnt_q + 5'd1;
                        drvb_q <= rd_data;
                    end
                end
                StStream: begin
                    if (cnt_q == 5'd24) begin
                        state_q <= StDrain;
                        cnt_q   <= 5'd0;
                        drva_q  <= 8'h00;
                    end else begin
                        cnt_q  <= cnt_q + 5'd1;
                        drva_q <= rd_data;
                    end
                end
                StDrain: begin
                    if (cnt_q == DrainLast) begin
                        state_q <= StCapture;
                        cnt_q   <= 5'd0;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                StCapture: begin
                    if (cnt_q == 5'd8) begin
                        state_q <= StDone;
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    cnt_q   <= 5'd0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= 5'd0;
                    busy_q  <= 1'b0;
                    drva_q  <= 8'h00;
                    drvb_q  <= 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 9; i++) begin
                res_q[i] <= 8'h00;
            end
        end else if (state_q == StCapture) begin
            res_q[cnt_q[3:0]] <= array_write;
        end
    end

    always_comb begin
        res_data = 8'h00;
        if (res_addr < 4'd9) begin
            res_data = res_q[res_addr];
        end
    end

`ifdef CONV_FEEDER_SAT_CNT_EN
    logic [3:0] sat_q;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            sat_q <= 4'd0;
        end else if (state_q == StIdle && start) begin
            sat_q <= 4'd0;
        end else if (state_q == StCapture && (array_write == 8'h7F || array_write == 8'h80)
                     && sat_q != 4'd15) begin
            sat_q <= sat_q + 4'd1;
        end
    end

    assign sat_cnt = sat_q;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign drvA = drva_q;
    assign drvB = drvb_q;

endmodule
